// File: rtl/pc_predict_unit.sv
// Fetch-stage program counter with a direct-mapped BTB and 2-bit saturating counters.
// Next PC is chosen from reset, execute redirect, stall hold, BTB prediction or sequential increment.
module pc_predict_unit #(
  parameter int               WIDTH        = 32,
  parameter int               BTB_DEPTH    = 16,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               INCREMENT    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             upd_valid,
  input  logic [WIDTH-1:0] upd_pc,
  input  logic [WIDTH-1:0] upd_target,
  input  logic             upd_taken,
  output logic [WIDTH-1:0] PC,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target
);

  localparam int IDX   = $clog2(BTB_DEPTH);
  localparam int TAG_W = WIDTH - 2 - IDX;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] target;
    logic [1:0]       ctr;
  } btb_entry_t;

  btb_entry_t       r_btb [BTB_DEPTH];
  logic [WIDTH-1:0] r_pc;

  logic [IDX-1:0]   w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  btb_entry_t       w_lk;
  logic             w_lk_hit;

  logic [IDX-1:0]   w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  btb_entry_t       w_up;
  logic             w_up_hit;
  logic [1:0]       w_ctr_inc;
  logic [1:0]       w_ctr_dec;

  logic [WIDTH-1:0] w_pc_next;
  logic             w_unused;

  // Lookup on the current fetch PC; reads pre-update contents, no write bypass.
  assign w_lk_idx    = r_pc[2 +: IDX];
  assign w_lk_tag    = r_pc[WIDTH-1 -: TAG_W];
  assign w_lk        = r_btb[w_lk_idx];
  assign w_lk_hit    = w_lk.valid && (w_lk.tag == w_lk_tag);
  assign pred_taken  = w_lk_hit && w_lk.ctr[1];
  assign pred_target = pred_taken ? w_lk.target : '0;
  assign PC          = r_pc;

  assign w_up_idx  = upd_pc[2 +: IDX];
  assign w_up_tag  = upd_pc[WIDTH-1 -: TAG_W];
  assign w_up      = r_btb[w_up_idx];
  assign w_up_hit  = w_up.valid && (w_up.tag == w_up_tag);
  assign w_ctr_inc = (w_up.ctr == 2'b11) ? 2'b11 : w_up.ctr + 2'd1;
  assign w_ctr_dec = (w_up.ctr == 2'b00) ? 2'b00 : w_up.ctr - 2'd1;

  // Byte-offset bits of the resolved PC never select an entry.
  assign w_unused = ^upd_pc[1:0];

  // NOTE: the default is assigned first so every path drives w_pc_next and no latch is inferred.
  always_comb begin
    w_pc_next = r_pc + WIDTH'(INCREMENT);
    if (redirect)        w_pc_next = redirect_pc;
    else if (stall)      w_pc_next = r_pc;
    else if (pred_taken) w_pc_next = pred_target;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge clk) begin
    if (rst) r_pc <= RESET_VECTOR;
    else     r_pc <= w_pc_next;
  end

  // NOTE: the BTB is built from flops and cleared on reset, because predictions must be off right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_DEPTH; i++) r_btb[i] <= '0;
    end else if (upd_valid) begin
      if (w_up_hit) begin
        r_btb[w_up_idx].ctr <= upd_taken ? w_ctr_inc : w_ctr_dec;
        if (upd_taken) r_btb[w_up_idx].target <= upd_target;
      end else if (upd_taken) begin
        r_btb[w_up_idx] <= '{valid: 1'b1, tag: w_up_tag, target: upd_target, ctr: 2'b10};
      end
    end
  end

endmodule
